// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter: captures a W-bit product on a valid/ready
// handshake and produces packed BCD after W shift-and-correct iterations.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a product; in_ready follows en
// SHIFT | one correct-then-shift iteration per enabled edge, W in total
// DONE  | bcd holds the new result; valid strobes for one enabled cycle
module bin_to_bcd #(
    parameter int inSize = 4,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [2*inSize-1:0]   bin,
    output logic                  in_ready,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  valid
);

    localparam int W  = 2 * inSize;
    localparam int CW = $clog2(W) + 1;
    localparam int SW = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    bin_sr;
    logic [SW-1:0]   scr;
    logic [CW-1:0]   cnt;

    logic [SW-1:0]   scr_cor;
    logic [SW-1:0]   scr_next;
    logic            last_iter;

    // Each digit is <= 9 before correction, so +3 never carries out of its nibble.
    always_comb begin
        scr_cor = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (scr[4*d +: 4] >= 4'd5)
                scr_cor[4*d +: 4] = scr[4*d +: 4] + 4'd3;
            else
                scr_cor[4*d +: 4] = scr[4*d +: 4];
        end
    end

    assign scr_next  = {scr_cor[SW-2:0], bin_sr[W-1]};
    assign last_iter = (cnt == CW'(W - 1));

    assign in_ready = (state == IDLE) && en;
    assign busy     = (state != IDLE);
    assign valid    = (state == DONE) && en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            bin_sr <= '0;
            scr    <= '0;
            cnt    <= '0;
            bcd    <= '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_sr <= bin;
                        scr    <= '0;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    scr    <= scr_next;
                    bin_sr <= {bin_sr[W-2:0], 1'b0};
                    cnt    <= cnt + CW'(1);
                    if (last_iter) begin
                        bcd   <= scr_next;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
